tqvp_uart_rx_ext: RTL and testbench

Parametrised successor UART receiver for tinyQV peripherals.
- Runtime-configurable frame: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits.
- Input synchroniser, false-start rejection, and a receive FIFO with per-entry error flags.
- Sticky overrun flag and FIFO-level-driven RTS flow control.
- Sits between the uart_rxd pad and the peripheral register interface.

---
 rtl/tqvp_uart_pkg.sv | 30 +++
 rtl/tqvp_uart_rx_fifo.sv | 54 +++++
 rtl/tqvp_uart_rx_ext.sv | 197 +++++++++++++++++++
 tb/tb_tqvp_uart_rx_ext.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_uart_pkg.sv
// Shared types and constants for the tinyQV extended UART receiver.
// Optional build macro: TQVP_UART_RX_MAJORITY_EN (3-sample majority voting).
package tqvp_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned DATA_LSB       = 0;
  localparam int unsigned FRAME_ERR_BIT  = 8;
  localparam int unsigned PARITY_ERR_BIT = 9;
  localparam int unsigned ENTRY_W        = 10;

  // Index of the last data bit for a given cfg_data_bits code.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] cfg);
    return 3'(cfg) + 3'd4;
  endfunction

endpackage

// File: rtl/tqvp_uart_rx_fifo.sv
// Receive FIFO: registered storage, combinational head, drops pushes when full
// unless a pop frees a slot in the same cycle.
module tqvp_uart_rx_fifo
  import tqvp_uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_entry,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head_c,
  output logic               o_empty_c,
  output logic               o_full_c,
  output logic               o_drop_c,
  output logic [AW:0]        o_level,
  output logic [AW:0]        o_level_next_c
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_rd;
  logic [AW-1:0]      r_wr;
  logic [AW:0]        r_level;
  logic               w_pop;
  logic               w_push_ok;

  assign o_empty_c      = (r_level == '0);
  assign o_full_c       = (r_level == (AW+1)'(DEPTH));
  assign w_pop          = i_pop && !o_empty_c;
  assign w_push_ok      = i_push && (!o_full_c || w_pop);
  assign o_drop_c       = i_push && !w_push_ok;
  assign o_level_next_c = r_level + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
  assign o_head_c       = o_empty_c ? '0 : r_mem[r_rd];
  assign o_level        = r_level;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_entry;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop)     r_rd <= r_rd + AW'(1);
      r_level <= o_level_next_c;
    end
  end

endmodule

// File: rtl/tqvp_uart_rx_ext.sv
// Configurable UART receiver (5-8 data bits, parity, 1/2 stop) with receive FIFO,
// sticky overrun and RTS flow control. Macro TQVP_UART_RX_MAJORITY_EN enables voting.
module tqvp_uart_rx_ext
  import tqvp_uart_pkg::*;
#(
  parameter  int unsigned COUNT_REG_LEN = 13,
  parameter  int unsigned FIFO_DEPTH    = 4,
  localparam int unsigned FIFO_AW       = $clog2(FIFO_DEPTH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     uart_rxd,
  output logic                     uart_rts,
  input  logic [COUNT_REG_LEN-1:0] baud_divider,
  input  logic [1:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_two_stop,
  input  logic                     rx_read,
  input  logic                     err_clear,
  output logic                     rx_valid,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     rx_frame_err,
  output logic                     rx_parity_err,
  output logic                     rx_overrun,
  output logic [FIFO_AW:0]         rx_level
);

  rx_state_e                r_state;
  rx_state_e                w_next;
  logic [1:0]               r_sync;
  logic                     w_rxd;
  logic [COUNT_REG_LEN-1:0] r_cnt;
  logic [COUNT_REG_LEN-1:0] w_half;
  logic                     w_samp_evt;
  logic                     w_samp;
  logic                     w_bit_end;
  logic [2:0]               r_idx;
  logic [2:0]               r_last_idx;
  logic                     r_par_en;
  logic                     r_par_odd;
  logic                     r_two_stop;
  logic [DATA_W-1:0]        r_data;
  logic                     r_perr;
  logic                     r_ferr;
  logic                     w_push;
  logic                     w_stop_err;
  logic [ENTRY_W-1:0]       w_entry;
  logic [ENTRY_W-1:0]       w_head;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_drop;
  logic [FIFO_AW:0]         w_level_next;
  logic                     r_overrun;
  logic                     r_rts;

  always_ff @(posedge clk) begin
    if (!resetn) r_sync <= 2'b11;
    else         r_sync <= {r_sync[0], uart_rxd};
  end
  assign w_rxd = r_sync[1];

  assign w_half    = baud_divider >> 1;
  assign w_bit_end = (r_cnt == baud_divider);

`ifdef TQVP_UART_RX_MAJORITY_EN
  // Two history flops give samples at half-1 and half; vote is taken at half+1.
  logic [1:0] r_hist;
  always_ff @(posedge clk) begin
    if (!resetn) r_hist <= 2'b11;
    else         r_hist <= {r_hist[0], w_rxd};
  end
  assign w_samp_evt = (r_cnt == w_half + COUNT_REG_LEN'(1));
  assign w_samp     = (w_rxd & r_hist[0]) | (w_rxd & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_samp_evt = (r_cnt == w_half);
  assign w_samp     = w_rxd;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (!w_rxd) w_next = ST_START;
      ST_START: begin
        if (w_samp_evt && w_samp) w_next = ST_IDLE;
        else if (w_bit_end)       w_next = ST_DATA;
      end
      ST_DATA:   if (w_bit_end && (r_idx == r_last_idx)) w_next = r_par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (w_bit_end) w_next = ST_STOP1;
      ST_STOP1: begin
        if (!r_two_stop && w_samp_evt)    w_next = ST_IDLE;
        else if (r_two_stop && w_bit_end) w_next = ST_STOP2;
      end
      ST_STOP2:  if (w_samp_evt) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Push at the last stop sample so a back-to-back start bit is not missed.
  always_comb begin
    w_push     = 1'b0;
    w_stop_err = r_ferr;
    case (r_state)
      ST_STOP1: begin
        w_stop_err = !w_samp;
        w_push     = w_samp_evt && !r_two_stop;
      end
      ST_STOP2: w_push = w_samp_evt;
      default:  ;
    endcase
    w_entry                        = '0;
    w_entry[DATA_LSB +: DATA_W]    = r_data;
    w_entry[FRAME_ERR_BIT]         = w_stop_err;
    w_entry[PARITY_ERR_BIT]        = r_perr;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
      r_data     <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
      if (!w_rxd) begin
        r_idx      <= '0;
        r_last_idx <= last_bit_idx(cfg_data_bits);
        r_par_en   <= cfg_parity_en;
        r_par_odd  <= cfg_parity_odd;
        r_two_stop <= cfg_two_stop;
        r_data     <= '0;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
      end
    end else begin
      r_cnt <= w_bit_end ? '0 : r_cnt + COUNT_REG_LEN'(1);
      if (w_samp_evt) begin
        case (r_state)
          ST_DATA:   r_data[r_idx] <= w_samp;
          ST_PARITY: r_perr <= w_samp ^ (^r_data) ^ r_par_odd;
          ST_STOP1:  r_ferr <= !w_samp;
          default:   ;
        endcase
      end
      if (w_bit_end && (r_state == ST_DATA)) r_idx <= r_idx + 3'd1;
    end
  end

  tqvp_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk            (clk),
    .resetn         (resetn),
    .i_push         (w_push),
    .i_entry        (w_entry),
    .i_pop          (rx_read),
    .o_head_c       (w_head),
    .o_empty_c      (w_empty),
    .o_full_c       (w_full),
    .o_drop_c       (w_drop),
    .o_level        (rx_level),
    .o_level_next_c (w_level_next)
  );

  // Overrun: set has priority over clear.
  always_ff @(posedge clk) begin
    if (!resetn)        r_overrun <= 1'b0;
    else if (w_drop)    r_overrun <= 1'b1;
    else if (err_clear) r_overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_rts <= 1'b1;
    else         r_rts <= (w_level_next >= (FIFO_AW+1)'(FIFO_DEPTH - 1));
  end

  logic w_unused_full;
  assign w_unused_full = w_full;

  assign uart_rts      = r_rts;
  assign rx_overrun    = r_overrun;
  assign rx_valid      = !w_empty;
  assign rx_data       = w_head[DATA_LSB +: DATA_W];
  assign rx_frame_err  = w_head[FRAME_ERR_BIT];
  assign rx_parity_err = w_head[PARITY_ERR_BIT];

endmodule

// File: tb/tb_tqvp_uart_rx_ext.sv
// Directed bench for tqvp_uart_rx_ext: frame formats, errors, FIFO/overrun/RTS, glitch, reset.
module tb_tqvp_uart_rx_ext;

  localparam int unsigned CRL   = 13;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIV   = 15;

  logic           clk = 1'b0;
  logic           resetn;
  logic           uart_rxd;
  logic           uart_rts;
  logic [CRL-1:0] baud_divider;
  logic [1:0]     cfg_data_bits;
  logic           cfg_parity_en;
  logic           cfg_parity_odd;
  logic           cfg_two_stop;
  logic           rx_read;
  logic           err_clear;
  logic           rx_valid;
  logic [7:0]     rx_data;
  logic           rx_frame_err;
  logic           rx_parity_err;
  logic           rx_overrun;
  logic [2:0]     rx_level;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tqvp_uart_rx_ext #(
    .COUNT_REG_LEN (CRL),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .uart_rxd       (uart_rxd),
    .uart_rts       (uart_rts),
    .baud_divider   (baud_divider),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_two_stop   (cfg_two_stop),
    .rx_read        (rx_read),
    .err_clear      (err_clear),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_frame_err   (rx_frame_err),
    .rx_parity_err  (rx_parity_err),
    .rx_overrun     (rx_overrun),
    .rx_level       (rx_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rxd = b;
    step(DIV + 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input logic par_bit, input logic stop1, input int nstop);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(stop1);
    for (int i = 1; i < nstop; i++) drive_bit(1'b1);
    uart_rxd = 1'b1;
    step(4);
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic pe, input logic po, input logic ts);
    cfg_data_bits  = db;
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_two_stop   = ts;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(2);
  endtask

  task automatic pop();
    rx_read = 1'b1;
    step(1);
    rx_read = 1'b0;
    step(1);
  endtask

  initial begin
    resetn         = 1'b0;
    uart_rxd       = 1'b1;
    baud_divider   = CRL'(DIV);
    rx_read        = 1'b0;
    err_clear      = 1'b0;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    step(3);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_level", 32'(rx_level), 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    check("rst_rts", 32'(uart_rts), 32'd1);
    check("rst_data", 32'(rx_data), 32'd0);
    resetn = 1'b1;
    step(3);
    check("rts_after_rst", 32'(uart_rts), 32'd0);

    // 8N1 basic frame
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1);
    check("8n1_valid", 32'(rx_valid), 32'd1);
    check("8n1_data", 32'(rx_data), 32'hA5);
    check("8n1_ferr", 32'(rx_frame_err), 32'd0);
    check("8n1_perr", 32'(rx_parity_err), 32'd0);
    check("8n1_level", 32'(rx_level), 32'd1);
    pop();
    check("8n1_pop_valid", 32'(rx_valid), 32'd0);

    // 7E1: 0x35 has four ones -> even parity bit is 0
    set_cfg(2'd2, 1'b1, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1);
    check("7e1_bad_data", 32'(rx_data), 32'h35);
    check("7e1_bad_perr", 32'(rx_parity_err), 32'd1);
    pop();
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1);
    check("7e1_ok_data", 32'(rx_data), 32'h35);
    check("7e1_ok_perr", 32'(rx_parity_err), 32'd0);
    pop();

    // 6O1: 0x2A has three ones -> odd parity bit is 0
    set_cfg(2'd1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h2A, 6, 1'b1, 1'b0, 1'b1, 1);
    check("6o1_ok_data", 32'(rx_data), 32'h2A);
    check("6o1_ok_perr", 32'(rx_parity_err), 32'd0);
    pop();
    send_frame(8'h2A, 6, 1'b1, 1'b1, 1'b1, 1);
    check("6o1_bad_perr", 32'(rx_parity_err), 32'd1);
    pop();

    // 5N2 with low first stop bit, then a break
    set_cfg(2'd0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 2);
    check("5n2_data", 32'(rx_data), 32'h1F);
    check("5n2_ferr", 32'(rx_frame_err), 32'd1);
    check("5n2_perr", 32'(rx_parity_err), 32'd0);
    pop();
    uart_rxd = 1'b0;
    step(12 * (DIV + 1));
    uart_rxd = 1'b1;
    step(3 * (DIV + 1));
    check("break_valid", 32'(rx_valid), 32'd1);
    check("break_data", 32'(rx_data), 32'h00);
    check("break_ferr", 32'(rx_frame_err), 32'd1);
    step(6 * (DIV + 1));
    do_reset();

    // Fill FIFO, watch RTS, overflow on fifth frame
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, 1);
      if (i == 2) check("rts_lvl2", 32'(uart_rts), 32'd0);
      if (i == 3) check("rts_lvl3", 32'(uart_rts), 32'd1);
      if (i == 4) check("ovr_lvl4", 32'(rx_overrun), 32'd0);
    end
    check("ovr_set", 32'(rx_overrun), 32'd1);
    check("ovr_level", 32'(rx_level), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_rd%0d", i), 32'(rx_data), 32'(i));
      pop();
    end
    check("ovr_empty", 32'(rx_valid), 32'd0);
    check("ovr_sticky", 32'(rx_overrun), 32'd1);
    check("rts_drained", 32'(uart_rts), 32'd0);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check("ovr_clear", 32'(rx_overrun), 32'd0);

    // Short glitch is rejected as a false start
    uart_rxd = 1'b0;
    step(4);
    uart_rxd = 1'b1;
    step(3 * (DIV + 1));
    check("glitch_level", 32'(rx_level), 32'd0);

    // Reset mid-DATA with two entries queued
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1);
    check("mid_pre_level", 32'(rx_level), 32'd2);
    uart_rxd = 1'b0;
    step((DIV + 1) + 40);
    resetn   = 1'b0;
    uart_rxd = 1'b1;
    step(1);
    check("mid_rst_level", 32'(rx_level), 32'd0);
    check("mid_rst_rts", 32'(uart_rts), 32'd1);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    step(1);
    resetn = 1'b1;
    step(3);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1);
    check("post_rst_data", 32'(rx_data), 32'h5A);
    check("post_rst_level", 32'(rx_level), 32'd1);
    check("post_rst_ferr", 32'(rx_frame_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
